// File: rtl/iob_cache_refill_ctrl.sv
// iob_cache_refill_ctrl
// Miss-side line refill engine. Picks a fill way (an invalid way if one
// exists, otherwise the replacement policy's victim), invalidates it, bursts
// the line in from the back-end, then writes the tag as valid and tells the
// policy which way was just filled.
module iob_cache_refill_ctrl #(
  parameter int N_WAYS        = 8,
  parameter int NWAYS_W       = $clog2(N_WAYS),
  parameter int SET_INDEX_W   = 7,
  parameter int TAG_W         = 20,
  parameter int WORD_OFFSET_W = 3,
  parameter int BE_DATA_W     = 32,
  parameter int BE_ADDR_W     = TAG_W + SET_INDEX_W + WORD_OFFSET_W + $clog2(BE_DATA_W/8)
) (
  input  logic                                 clk_i,
  input  logic                                 arst_n_i,
  input  logic                                 cke_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [TAG_W-1:0]                     req_tag_i,
  input  logic [SET_INDEX_W-1:0]               req_index_i,
  output logic [SET_INDEX_W-1:0]               line_addr_o,
  input  logic [N_WAYS-1:0]                    way_valid_i,
  input  logic [NWAYS_W-1:0]                   way_select_bin_i,
  output logic                                 be_valid_o,
  output logic [BE_ADDR_W-1:0]                 be_addr_o,
  input  logic                                 be_ready_i,
  input  logic                                 be_rvalid_i,
  input  logic [BE_DATA_W-1:0]                 be_rdata_i,
  output logic [N_WAYS-1:0]                    dmem_we_o,
  output logic [SET_INDEX_W+WORD_OFFSET_W-1:0] dmem_addr_o,
  output logic [BE_DATA_W-1:0]                 dmem_wdata_o,
  output logic [N_WAYS-1:0]                    tag_we_o,
  output logic [TAG_W-1:0]                     tag_o,
  output logic                                 tag_valid_o,
  output logic                                 pol_we_o,
  output logic [N_WAYS-1:0]                    pol_way_hit_o,
  output logic                                 done_o,
  output logic [NWAYS_W-1:0]                   fill_way_o
);

  localparam int BYTE_OFF_W = $clog2(BE_DATA_W/8);
  localparam int LINE_OFF_W = WORD_OFFSET_W + BYTE_OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    INVAL,
    ADDR,
    DATA,
    UPDATE
  } state_t;

  state_t                    state, state_nxt;
  logic [TAG_W-1:0]          tag_q, tag_nxt;
  logic [SET_INDEX_W-1:0]    index_q, index_nxt;
  logic [WORD_OFFSET_W-1:0]  cnt_q, cnt_nxt;
  logic [NWAYS_W-1:0]        fill_way_q, fill_way_nxt;
  logic [N_WAYS-1:0]         fill_onehot;
  logic [NWAYS_W-1:0]        first_invalid;
  logic                      any_invalid;

  // Latched request and fill way feed the memories directly, so they stay
  // stable for the whole refill and read as zero out of reset.
  assign line_addr_o = index_q;
  assign tag_o       = tag_q;
  assign fill_way_o  = fill_way_q;
  assign be_addr_o   = {tag_q, index_q, {LINE_OFF_W{1'b0}}};
  assign dmem_addr_o = {index_q, cnt_q};
  assign fill_onehot = {{(N_WAYS-1){1'b0}}, 1'b1} << fill_way_q;

  // Lowest-index invalid way; scanning downward lets the lowest index win.
  always_comb begin
    any_invalid   = 1'b0;
    first_invalid = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        any_invalid   = 1'b1;
        first_invalid = NWAYS_W'(i);
      end
    end
  end

  // State and latched context; a low clock enable freezes everything.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= IDLE;
      tag_q      <= '0;
      index_q    <= '0;
      cnt_q      <= '0;
      fill_way_q <= '0;
    end else if (cke_i) begin
      state      <= state_nxt;
      tag_q      <= tag_nxt;
      index_q    <= index_nxt;
      cnt_q      <= cnt_nxt;
      fill_way_q <= fill_way_nxt;
    end
  end

  // Next state and strobes; every strobe is gated by cke_i so a frozen
  // cycle never writes and the address handshake cannot complete.
  always_comb begin
    state_nxt     = state;
    tag_nxt       = tag_q;
    index_nxt     = index_q;
    cnt_nxt       = cnt_q;
    fill_way_nxt  = fill_way_q;
    req_ready_o   = 1'b0;
    be_valid_o    = 1'b0;
    dmem_we_o     = '0;
    dmem_wdata_o  = '0;
    tag_we_o      = '0;
    tag_valid_o   = 1'b0;
    pol_we_o      = 1'b0;
    pol_way_hit_o = '0;
    done_o        = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          tag_nxt   = req_tag_i;
          index_nxt = req_index_i;
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        fill_way_nxt = any_invalid ? first_invalid : way_select_bin_i;
        state_nxt    = INVAL;
      end
      INVAL: begin
        tag_we_o  = cke_i ? fill_onehot : '0;
        state_nxt = ADDR;
      end
      ADDR: begin
        be_valid_o = cke_i;
        if (be_ready_i) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        dmem_wdata_o = be_rdata_i;
        if (be_rvalid_i) begin
          dmem_we_o = cke_i ? fill_onehot : '0;
          cnt_nxt   = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_nxt = UPDATE;
          end
        end
      end
      UPDATE: begin
        tag_we_o      = cke_i ? fill_onehot : '0;
        tag_valid_o   = cke_i;
        pol_we_o      = cke_i;
        pol_way_hit_o = cke_i ? fill_onehot : '0;
        done_o        = cke_i;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_cache_refill_ctrl.sv
// tb_iob_cache_refill_ctrl
// Acts as the cache FSM and back-end around the refill controller. A
// transaction-level model predicts the fill way and the ordered list of
// tag, data and policy writes; a negedge monitor checks every write event.
module tb_iob_cache_refill_ctrl;

  localparam int N_WAYS        = 8;
  localparam int NWAYS_W       = 3;
  localparam int SET_INDEX_W   = 7;
  localparam int TAG_W         = 20;
  localparam int WORD_OFFSET_W = 3;
  localparam int BE_DATA_W     = 32;
  localparam int BE_ADDR_W     = 32;
  localparam int BEATS         = 8;

  logic                                 clk_i = 1'b0;
  logic                                 arst_n_i = 1'b0;
  logic                                 cke_i = 1'b1;
  logic                                 req_valid_i = 1'b0;
  logic                                 req_ready_o;
  logic [TAG_W-1:0]                     req_tag_i = '0;
  logic [SET_INDEX_W-1:0]               req_index_i = '0;
  logic [SET_INDEX_W-1:0]               line_addr_o;
  logic [N_WAYS-1:0]                    way_valid_i = '0;
  logic [NWAYS_W-1:0]                   way_select_bin_i = '0;
  logic                                 be_valid_o;
  logic [BE_ADDR_W-1:0]                 be_addr_o;
  logic                                 be_ready_i = 1'b0;
  logic                                 be_rvalid_i = 1'b0;
  logic [BE_DATA_W-1:0]                 be_rdata_i = '0;
  logic [N_WAYS-1:0]                    dmem_we_o;
  logic [SET_INDEX_W+WORD_OFFSET_W-1:0] dmem_addr_o;
  logic [BE_DATA_W-1:0]                 dmem_wdata_o;
  logic [N_WAYS-1:0]                    tag_we_o;
  logic [TAG_W-1:0]                     tag_o;
  logic                                 tag_valid_o;
  logic                                 pol_we_o;
  logic [N_WAYS-1:0]                    pol_way_hit_o;
  logic                                 done_o;
  logic [NWAYS_W-1:0]                   fill_way_o;

  typedef struct {
    logic [N_WAYS-1:0]                    we;
    logic [SET_INDEX_W+WORD_OFFSET_W-1:0] addr;
    logic [BE_DATA_W-1:0]                 data;
  } beat_t;

  typedef struct {
    logic [N_WAYS-1:0] we;
    logic              valid;
    logic [TAG_W-1:0]  tag;
  } tag_ev_t;

  beat_t             exp_beat_q[$];
  tag_ev_t           exp_tag_q[$];
  logic [N_WAYS-1:0] exp_pol_q[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int write_count = 0;

  logic [NWAYS_W-1:0]   last_fill_way;
  logic [BE_ADDR_W-1:0] last_be_addr;
  logic [N_WAYS-1:0]    last_inval_tag_we;
  logic                 last_inval_valid;
  logic [N_WAYS-1:0]    last_update_tag_we;
  logic [N_WAYS-1:0]    last_pol_hit;

  iob_cache_refill_ctrl dut (
    .clk_i            (clk_i),
    .arst_n_i         (arst_n_i),
    .cke_i            (cke_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_tag_i        (req_tag_i),
    .req_index_i      (req_index_i),
    .line_addr_o      (line_addr_o),
    .way_valid_i      (way_valid_i),
    .way_select_bin_i (way_select_bin_i),
    .be_valid_o       (be_valid_o),
    .be_addr_o        (be_addr_o),
    .be_ready_i       (be_ready_i),
    .be_rvalid_i      (be_rvalid_i),
    .be_rdata_i       (be_rdata_i),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .tag_we_o         (tag_we_o),
    .tag_o            (tag_o),
    .tag_valid_o      (tag_valid_o),
    .pol_we_o         (pol_we_o),
    .pol_way_hit_o    (pol_way_hit_o),
    .done_o           (done_o),
    .fill_way_o       (fill_way_o)
  );

  // Free-running clock and a cycle counter for latency checks.
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference rule: lowest invalid way wins, otherwise the policy victim.
  function automatic logic [NWAYS_W-1:0] model_fill_way(input logic [N_WAYS-1:0] valid,
                                                        input logic [NWAYS_W-1:0] victim);
    for (int i = 0; i < N_WAYS; i++) begin
      if (!valid[i]) return NWAYS_W'(i);
    end
    return victim;
  endfunction

  function automatic logic [N_WAYS-1:0] onehot(input logic [NWAYS_W-1:0] w);
    return N_WAYS'(1) << w;
  endfunction

  // Monitor: every write strobe must match the next predicted event.
  always @(negedge clk_i) begin
    if (dmem_we_o != '0) begin
      write_count++;
      if (exp_beat_q.size() == 0) begin
        checkOutput("dmem_we_unexpected", dmem_we_o, 0);
      end else begin
        beat_t e;
        e = exp_beat_q.pop_front();
        checkOutput("dmem_we", dmem_we_o, e.we);
        checkOutput("dmem_addr", dmem_addr_o, e.addr);
        checkOutput("dmem_wdata", dmem_wdata_o, e.data);
      end
    end
    if (tag_we_o != '0) begin
      if (exp_tag_q.size() == 0) begin
        checkOutput("tag_we_unexpected", tag_we_o, 0);
      end else begin
        tag_ev_t t;
        t = exp_tag_q.pop_front();
        checkOutput("tag_we", tag_we_o, t.we);
        checkOutput("tag_valid", tag_valid_o, t.valid);
        checkOutput("tag_value", tag_o, t.tag);
        if (t.valid) last_update_tag_we = tag_we_o;
        else begin
          last_inval_tag_we = tag_we_o;
          last_inval_valid  = tag_valid_o;
        end
      end
    end
    if (pol_we_o || done_o) begin
      if (exp_pol_q.size() == 0) begin
        checkOutput("pol_done_unexpected", {pol_we_o, done_o}, 0);
      end else begin
        logic [N_WAYS-1:0] h;
        h = exp_pol_q.pop_front();
        checkOutput("pol_we", pol_we_o, 1);
        checkOutput("done", done_o, 1);
        checkOutput("pol_way_hit", pol_way_hit_o, h);
        last_pol_hit = pol_way_hit_o;
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rst_req_ready", req_ready_o, 1);
    checkOutput("rst_line_addr", line_addr_o, 0);
    checkOutput("rst_be_valid", be_valid_o, 0);
    checkOutput("rst_be_addr", be_addr_o, 0);
    checkOutput("rst_dmem_we", dmem_we_o, 0);
    checkOutput("rst_dmem_addr", dmem_addr_o, 0);
    checkOutput("rst_dmem_wdata", dmem_wdata_o, 0);
    checkOutput("rst_tag_we", tag_we_o, 0);
    checkOutput("rst_tag", tag_o, 0);
    checkOutput("rst_tag_valid", tag_valid_o, 0);
    checkOutput("rst_pol", {pol_we_o, pol_way_hit_o}, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_fill_way", fill_way_o, 0);
  endtask

  // Abort mid-burst: nothing more may be written, outputs must clear at once.
  task automatic abortWithReset(input logic [BE_DATA_W-1:0] data);
    exp_beat_q.delete();
    exp_tag_q.delete();
    exp_pol_q.delete();
    be_rvalid_i = 1'b1;
    be_rdata_i  = data;
    arst_n_i    = 1'b0;
    #1;
    checkResetState();
    for (int k = 0; k < 2; k++) begin
      step();
      checkOutput("rst_hold_dmem_we", dmem_we_o, 0);
      checkOutput("rst_hold_ready", req_ready_o, 1);
    end
    be_rvalid_i = 1'b0;
    arst_n_i    = 1'b1;
    step();
  endtask

  // One refill: request, address handshake with optional back-pressure,
  // a burst with gaps/clock-enable freeze/reset abort, then completion.
  task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic [SET_INDEX_W-1:0] index,
                               input logic [N_WAYS-1:0] valid, input logic [NWAYS_W-1:0] victim,
                               input logic [BE_DATA_W-1:0] data_base, input int ready_delay,
                               input int gap_mode, input int cke_beat, input int reset_beat,
                               input bit check_latency);
    logic [NWAYS_W-1:0]   way;
    logic [BE_ADDR_W-1:0] addr;
    tag_ev_t              tev;
    beat_t                bev;
    int                   c0;
    int                   gaps;
    bit                   got;
    way  = model_fill_way(valid, victim);
    addr = {tag, index, 5'd0};
    checkOutput("req_ready_idle", req_ready_o, 1);
    tev = '{we: onehot(way), valid: 1'b0, tag: tag};
    exp_tag_q.push_back(tev);
    tev.valid = 1'b1;
    exp_tag_q.push_back(tev);
    exp_pol_q.push_back(onehot(way));

    req_valid_i      = 1'b1;
    req_tag_i        = tag;
    req_index_i      = index;
    way_valid_i      = valid;
    way_select_bin_i = victim;
    be_ready_i       = (ready_delay == 0);
    be_rvalid_i      = 1'($urandom);
    be_rdata_i       = $urandom;
    step();
    c0          = cyc;
    req_valid_i = 1'b0;
    req_tag_i   = TAG_W'($urandom);
    req_index_i = SET_INDEX_W'($urandom);
    checkOutput("line_addr_select", line_addr_o, index);
    checkOutput("req_ready_busy", req_ready_o, 0);
    step();
    way_valid_i      = N_WAYS'($urandom);
    way_select_bin_i = NWAYS_W'($urandom);
    checkOutput("fill_way", fill_way_o, way);
    last_fill_way = fill_way_o;

    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      step();
      got = be_valid_o;
    end
    if (!got) begin
      checkOutput("be_valid_timeout", be_valid_o, 1);
      exp_beat_q.delete();
      exp_tag_q.delete();
      exp_pol_q.delete();
      return;
    end
    if (check_latency) checkOutput("addr_latency", cyc - c0, 2);
    last_be_addr = be_addr_o;
    for (int i = 0; i < ready_delay; i++) begin
      checkOutput("be_valid_hold", be_valid_o, 1);
      checkOutput("be_addr_hold", be_addr_o, addr);
      be_rvalid_i = 1'($urandom);
      step();
    end
    be_ready_i = 1'b1;
    checkOutput("be_valid", be_valid_o, 1);
    checkOutput("be_addr", be_addr_o, addr);
    step();
    be_ready_i = 1'b0;
    checkOutput("be_valid_data", be_valid_o, 0);

    for (int b = 0; b < BEATS; b++) begin
      if (gap_mode == 1) gaps = (b > 0) ? 1 : 0;
      else if (gap_mode == 2) gaps = $urandom_range(0, 2);
      else gaps = 0;
      for (int g = 0; g < gaps; g++) begin
        be_rvalid_i = 1'b0;
        be_rdata_i  = $urandom;
        step();
      end
      if (b == reset_beat) begin
        abortWithReset(data_base + BE_DATA_W'(b));
        return;
      end
      bev = '{we: onehot(way), addr: {index, 3'(b)}, data: data_base + BE_DATA_W'(b)};
      exp_beat_q.push_back(bev);
      be_rvalid_i = 1'b1;
      be_rdata_i  = data_base + BE_DATA_W'(b);
      if (b == cke_beat) begin
        cke_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          checkOutput("cke_low_no_write", dmem_we_o, 0);
          step();
        end
        cke_i = 1'b1;
      end
      step();
    end
    be_rvalid_i = 1'b0;
    checkOutput("done_after_last_beat", done_o, 1);
    if (check_latency) checkOutput("done_latency", cyc - c0, 11);
    step();
    checkOutput("ready_after_done", req_ready_o, 1);
    checkOutput("done_pulse_width", done_o, 0);
    checkOutput("beats_left", exp_beat_q.size(), 0);
    checkOutput("tag_events_left", exp_tag_q.size(), 0);
    checkOutput("pol_events_left", exp_pol_q.size(), 0);
  endtask

  initial begin
    $display("[TB] start");
    step();
    step();
    checkResetState();
    arst_n_i = 1'b1;
    step();

    // Stray read beats while idle must be ignored.
    be_rvalid_i = 1'b1;
    be_rdata_i  = 32'hDEAD_BEEF;
    step();
    step();
    be_rvalid_i = 1'b0;

    // Invalid way preferred over victim, minimum latency.
    applyStimulus(20'h12345, 7'd5, 8'b1111_0111, 3'd6, 32'h100, 0, 0, -1, -1, 1'b1);
    checkOutput("lit_fill_way_invalid", last_fill_way, 3);
    checkOutput("lit_be_addr", last_be_addr, {20'h12345, 7'd5, 5'd0});
    checkOutput("lit_update_tag_we", last_update_tag_we, 8'b0000_1000);
    checkOutput("lit_pol_hit", last_pol_hit, 8'b0000_1000);

    // All ways valid: the policy victim is used.
    applyStimulus(20'hABCDE, 7'd100, 8'hFF, 3'd6, 32'h200, 0, 0, -1, -1, 1'b1);
    checkOutput("lit_fill_way_victim", last_fill_way, 6);
    checkOutput("lit_inval_tag_we", last_inval_tag_we, 8'h40);
    checkOutput("lit_inval_valid", last_inval_valid, 0);

    // Burst with a gap between every beat.
    write_count = 0;
    applyStimulus(20'h00F0F, 7'd33, 8'hFF, 3'd1, 32'hA0, 0, 1, -1, -1, 1'b0);
    checkOutput("lit_gap_write_count", write_count, 8);

    // Back-pressure on the address channel for 4 cycles.
    write_count = 0;
    applyStimulus(20'h55555, 7'd127, 8'b1111_1110, 3'd4, 32'h300, 4, 0, -1, -1, 1'b0);
    checkOutput("lit_bp_write_count", write_count, 8);
    checkOutput("lit_bp_fill_way", last_fill_way, 0);

    // Reset after beat 3, then a fresh request completes.
    write_count = 0;
    applyStimulus(20'h0BEEF, 7'd9, 8'hFF, 3'd2, 32'h400, 0, 0, -1, 4, 1'b0);
    checkOutput("lit_reset_write_count", write_count, 4);
    applyStimulus(20'h0CAFE, 7'd10, 8'h7F, 3'd2, 32'h500, 1, 0, -1, -1, 1'b0);
    checkOutput("lit_after_reset_writes", write_count, 12);
    checkOutput("lit_after_reset_fill_way", last_fill_way, 7);

    // Clock enable low for 3 cycles with a beat held.
    write_count = 0;
    applyStimulus(20'h13579, 7'd64, 8'hFF, 3'd5, 32'h600, 0, 0, 2, -1, 1'b0);
    checkOutput("lit_cke_write_count", write_count, 8);

    // Randomized refills.
    for (int n = 0; n < 24; n++) begin
      logic [N_WAYS-1:0] v;
      int                cb;
      v  = ($urandom_range(0, 1) == 1) ? 8'hFF : N_WAYS'($urandom);
      cb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      applyStimulus(TAG_W'($urandom), SET_INDEX_W'($urandom), v, NWAYS_W'($urandom),
                    $urandom, $urandom_range(0, 3), 2, cb, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
